// File: rtl/otter_mem_port_ctrl_if.sv
// Single-port memory bus between otter_mem_port_ctrl (master) and memory (slave).
// Handshake: master holds bus_req until memory returns a one-cycle bus_ack.
interface otter_mem_port_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/otter_mem_port_ctrl.sv
// Otter memory-port controller: serialises fetch/load/store strobes onto one req/ack bus.
// Optional macro MEM_PORT_FETCH_BUF_EN adds a one-entry fetch address buffer.
//
// state  | meaning
// IDLE   | waiting for a strobe; busy follows the strobes
// REQ    | bus_req held until bus_ack or timeout
// ABORT  | one-cycle stall after a fault, then IDLE
module otter_mem_port_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    memRDEN1_i,
    input  logic                    memRDEN2_i,
    input  logic                    memWE2_i,
    input  logic [31:0]             pc_addr_i,
    input  logic [31:0]             data_addr_i,
    input  logic [31:0]             wdata_i,
    input  logic [1:0]              size_i,
    input  logic                    sign_n_i,
    output logic [31:0]             ir_out_o,
    output logic [31:0]             rdata_out_o,
    output logic                    busy_o,
    output logic                    err_o,
    otter_mem_port_ctrl_if.master   bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ABORT} state_t;
    typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sign_n_q, sign_n_d;
    logic [31:0] wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        strobe_any;
    kind_t       acc_kind;
    logic [31:0] acc_addr;
    logic        acc_fault;
    logic        fb_hit;
    logic [31:0] rd_shift;
    logic [31:0] load_val;
    logic [CNT_W-1:0] cnt_inc;

`ifdef MEM_PORT_FETCH_BUF_EN
    logic        fb_valid_q, fb_valid_d;
    logic [31:0] fb_addr_q, fb_addr_d;
`endif

    assign strobe_any = memWE2_i | memRDEN2_i | memRDEN1_i;
    assign busy_o     = (state_q != S_IDLE) | strobe_any;
    assign ir_out_o    = ir_q;
    assign rdata_out_o = rdata_q;
    assign err_o       = err_q;
    assign cnt_inc     = cnt_q + 1'b1;

    // Accept decode: store beats load beats fetch
    always_comb begin
        acc_kind  = K_FETCH;
        acc_addr  = pc_addr_i;
        acc_fault = 1'b0;
        if (memWE2_i) begin
            acc_kind = K_STORE;
            acc_addr = data_addr_i;
        end else if (memRDEN2_i) begin
            acc_kind = K_LOAD;
            acc_addr = data_addr_i;
        end
        if (acc_kind == K_FETCH) begin
            acc_fault = (pc_addr_i[1:0] != 2'b00);
        end else begin
            case (size_i)
                2'b00:   acc_fault = 1'b0;
                2'b01:   acc_fault = acc_addr[0];
                2'b10:   acc_fault = (acc_addr[1:0] != 2'b00);
                default: acc_fault = 1'b1;
            endcase
        end
    end

`ifdef MEM_PORT_FETCH_BUF_EN
    assign fb_hit = (acc_kind == K_FETCH) && fb_valid_q && (fb_addr_q == pc_addr_i);
`else
    assign fb_hit = 1'b0;
`endif

    // Lane 0 of rd_shift holds the addressed byte/half
    assign rd_shift = bus.bus_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_val = {{24{~sign_n_q & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = {{16{~sign_n_q & rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_shift;
        endcase
    end

    always_comb begin
        bus.bus_req   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = 32'h0;
        bus.bus_wdata = 32'h0;
        bus.bus_be    = 4'h0;
        if (state_q == S_REQ) begin
            bus.bus_req  = 1'b1;
            bus.bus_addr = {addr_q[31:2], 2'b00};
            bus.bus_be   = 4'b1111;
            if (kind_q == K_STORE) begin
                bus.bus_we = 1'b1;
                case (size_q)
                    2'b00: begin
                        bus.bus_be    = 4'b0001 << addr_q[1:0];
                        bus.bus_wdata = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        bus.bus_be    = 4'b0011 << addr_q[1:0];
                        bus.bus_wdata = {2{wdata_q[15:0]}};
                    end
                    default: bus.bus_wdata = wdata_q;
                endcase
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        addr_d   = addr_q;
        size_d   = size_q;
        sign_n_d = sign_n_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        ir_d     = ir_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef MEM_PORT_FETCH_BUF_EN
        fb_valid_d = fb_valid_q;
        fb_addr_d  = fb_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (strobe_any) begin
                    kind_d   = acc_kind;
                    addr_d   = acc_addr;
                    size_d   = size_i;
                    sign_n_d = sign_n_i;
                    wdata_d  = wdata_i;
                    cnt_d    = '0;
`ifdef MEM_PORT_FETCH_BUF_EN
                    if (acc_kind == K_STORE) fb_valid_d = 1'b0;
`endif
                    if (acc_fault) begin
                        err_d   = 1'b1;
                        state_d = S_ABORT;
                    end else if (!fb_hit) begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.bus_ack) begin
                    if (kind_q == K_FETCH) begin
                        ir_d = bus.bus_rdata;
`ifdef MEM_PORT_FETCH_BUF_EN
                        fb_valid_d = 1'b1;
                        fb_addr_d  = addr_q;
`endif
                    end else if (kind_q == K_LOAD) begin
                        rdata_d = load_val;
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            kind_q   <= K_FETCH;
            addr_q   <= 32'h0;
            size_q   <= 2'b00;
            sign_n_q <= 1'b0;
            wdata_q  <= 32'h0;
            cnt_q    <= '0;
            ir_q     <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
`ifdef MEM_PORT_FETCH_BUF_EN
            fb_valid_q <= 1'b0;
            fb_addr_q  <= 32'h0;
`endif
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            sign_n_q <= sign_n_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            ir_q     <= ir_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef MEM_PORT_FETCH_BUF_EN
            fb_valid_q <= fb_valid_d;
            fb_addr_q  <= fb_addr_d;
`endif
        end
    end

endmodule
